// File: rtl/input_pin_capture_if.sv
// Processor-side bus bundle for the input pin peripheral: a write port used
// to clear the sticky edge flags and a strobed read port returning one
// register per strobe.
interface input_pin_capture_if;

  logic [7:0] OUTBUS_ADDR;
  logic [7:0] OUTBUS_DATA;
  logic       OUTBUS_WE;
  logic [7:0] INBUS_ADDR;
  logic [7:0] INBUS_DATA;
  logic       INBUS_RE;

  // Processor side: issues writes and read strobes, receives read data
  modport master (
    output OUTBUS_ADDR,
    output OUTBUS_DATA,
    output OUTBUS_WE,
    output INBUS_ADDR,
    output INBUS_RE,
    input  INBUS_DATA
  );

  // Peripheral side: decodes writes and read strobes, drives read data
  modport slave (
    input  OUTBUS_ADDR,
    input  OUTBUS_DATA,
    input  OUTBUS_WE,
    input  INBUS_ADDR,
    input  INBUS_RE,
    output INBUS_DATA
  );

endinterface

// File: rtl/input_pin_capture.sv
// Bus-mapped input pin peripheral. Each raw pin goes through a two-flop
// synchronizer and a per-pin debounce counter; the accepted (debounced)
// level is readable at DEVADDR+0, and sticky rise/fall flags derived from
// that level are readable at DEVADDR+1/+2 and cleared by writing ones.
// Read data is registered and is zero in every cycle that does not answer
// a strobe, so it can be OR-ed directly into the processor read bus.
module input_pin_capture #(
  parameter int         PIN_WIDTH       = 5,
  parameter logic [7:0] DEVADDR         = 8'h58,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIN_WIDTH-1:0] INPUT_PIN,
  input_pin_capture_if.slave   bus,
  output logic                 EVENT
);

  // The counter needs to hold DEBOUNCE_CYCLES-1; one extra bit keeps the
  // width non-zero when DEBOUNCE_CYCLES is 1.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] ADDR_LEVEL = DEVADDR;
  localparam logic [7:0] ADDR_RISE  = DEVADDR + 8'd1;
  localparam logic [7:0] ADDR_FALL  = DEVADDR + 8'd2;

  logic [PIN_WIDTH-1:0] r_sync1;
  logic [PIN_WIDTH-1:0] r_sync2;
  logic [PIN_WIDTH-1:0] r_level;
  logic [CNT_W-1:0]     r_cnt [PIN_WIDTH];
  logic [PIN_WIDTH-1:0] r_rise;
  logic [PIN_WIDTH-1:0] r_fall;
  logic [7:0]           r_inbusData;
  logic                 r_event;

  logic [PIN_WIDTH-1:0] w_levelNext;
  logic [CNT_W-1:0]     w_cntNext [PIN_WIDTH];
  logic [PIN_WIDTH-1:0] w_riseSet;
  logic [PIN_WIDTH-1:0] w_fallSet;
  logic [PIN_WIDTH-1:0] w_riseClr;
  logic [PIN_WIDTH-1:0] w_fallClr;
  logic [PIN_WIDTH-1:0] w_riseNext;
  logic [PIN_WIDTH-1:0] w_fallNext;
  logic [7:0]           w_readData;
  logic                 w_unusedBits;

  // Bring the asynchronous pins into the clk domain through two flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= INPUT_PIN;
      r_sync2 <= r_sync1;
    end
  end

  // Per pin: count consecutive cycles the synced value disagrees with the
  // accepted level; accept it on the DEBOUNCE_CYCLES-th, restart on agreement
  always_comb begin
    w_levelNext = r_level;
    for (int i = 0; i < PIN_WIDTH; i++) begin
      w_cntNext[i] = r_cnt[i];
      if (r_sync2[i] == r_level[i]) begin
        w_cntNext[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_levelNext[i] = r_sync2[i];
        w_cntNext[i]   = '0;
      end else begin
        w_cntNext[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  // Hold the accepted level and the per-pin debounce counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level <= '0;
      for (int i = 0; i < PIN_WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_level <= w_levelNext;
      for (int i = 0; i < PIN_WIDTH; i++) begin
        r_cnt[i] <= w_cntNext[i];
      end
    end
  end

  // Edge detection on the accepted level and write-one-to-clear decode;
  // a set in the same cycle as a clear wins so no edge is ever lost
  always_comb begin
    w_riseSet = w_levelNext & ~r_level;
    w_fallSet = r_level & ~w_levelNext;
    w_riseClr = '0;
    w_fallClr = '0;
    if (bus.OUTBUS_WE) begin
      if (bus.OUTBUS_ADDR == ADDR_RISE) begin
        w_riseClr = PIN_WIDTH'(bus.OUTBUS_DATA);
      end else if (bus.OUTBUS_ADDR == ADDR_FALL) begin
        w_fallClr = PIN_WIDTH'(bus.OUTBUS_DATA);
      end
    end
    w_riseNext = (r_rise & ~w_riseClr) | w_riseSet;
    w_fallNext = (r_fall & ~w_fallClr) | w_fallSet;
  end

  // Sticky flags, with EVENT computed from the same next values so it
  // changes on the very edge the flag register does
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise  <= '0;
      r_fall  <= '0;
      r_event <= 1'b0;
    end else begin
      r_rise  <= w_riseNext;
      r_fall  <= w_fallNext;
      r_event <= |{w_riseNext, w_fallNext};
    end
  end

  // Select the addressed register for a read strobe; zero otherwise so the
  // shared read bus is not disturbed
  always_comb begin
    w_readData = 8'h00;
    if (bus.INBUS_RE) begin
      if (bus.INBUS_ADDR == ADDR_LEVEL) begin
        w_readData = 8'(r_level);
      end else if (bus.INBUS_ADDR == ADDR_RISE) begin
        w_readData = 8'(r_rise);
      end else if (bus.INBUS_ADDR == ADDR_FALL) begin
        w_readData = 8'(r_fall);
      end
    end
  end

  // Register read data: valid for exactly the one cycle after the strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inbusData <= 8'h00;
    end else begin
      r_inbusData <= w_readData;
    end
  end

  // Write data bits above PIN_WIDTH have no flag to clear
  assign w_unusedBits = ^bus.OUTBUS_DATA;

  assign bus.INBUS_DATA = r_inbusData;
  assign EVENT          = r_event;

endmodule

// File: tb/tb_input_pin_capture.sv
// Bench for input_pin_capture: directed pin/bus sequences with literal
// expectations, plus a time-based model of the peripheral that is compared
// against INBUS_DATA and EVENT after every clock edge.
module tb_input_pin_capture;

  localparam int         PW    = 5;
  localparam logic [7:0] DEV   = 8'h58;
  localparam int         DEB   = 16;

  logic          clk;
  logic          reset;
  logic [PW-1:0] pins;
  logic          evt;

  int checks = 0;
  int fails  = 0;

  input_pin_capture_if busIf();

  input_pin_capture #(
    .PIN_WIDTH      (PW),
    .DEVADDR        (DEV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .INPUT_PIN(pins),
    .bus      (busIf.slave),
    .EVENT    (evt)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: pin samples since reset, accepted level, flags, outputs
  logic [PW-1:0] pinHist [$];
  logic [PW-1:0] mLevel = '0;
  logic [PW-1:0] mRise  = '0;
  logic [PW-1:0] mFall  = '0;
  logic [PW-1:0] sPrev  = '0;
  logic [PW-1:0] sNow   = '0;
  logic [PW-1:0] lvlNew = '0;
  logic [7:0]    mData  = 8'h00;
  logic          mEvent = 1'b0;
  int            edgeIdx = 0;
  int            runStart [PW];

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a pin value is seen by the debouncer two edges after it is
  // sampled; the level takes a new value once that value has been held for
  // DEB edges. Outputs are then checked just after each edge.
  always @(posedge clk) begin
    if (reset) begin
      pinHist.delete();
      mLevel  = '0;
      mRise   = '0;
      mFall   = '0;
      sPrev   = '0;
      mData   = 8'h00;
      mEvent  = 1'b0;
      edgeIdx = 0;
      for (int i = 0; i < PW; i++) runStart[i] = 0;
    end else begin
      edgeIdx++;
      sNow = (pinHist.size() >= 2) ? pinHist[pinHist.size()-2] : '0;
      mData = 8'h00;
      if (busIf.INBUS_RE) begin
        if (busIf.INBUS_ADDR == DEV)             mData = {3'b000, mLevel};
        else if (busIf.INBUS_ADDR == DEV + 8'd1) mData = {3'b000, mRise};
        else if (busIf.INBUS_ADDR == DEV + 8'd2) mData = {3'b000, mFall};
      end
      for (int i = 0; i < PW; i++) begin
        if (sNow[i] != sPrev[i]) runStart[i] = edgeIdx;
        lvlNew[i] = mLevel[i];
        if (sNow[i] != mLevel[i] && (edgeIdx - runStart[i] + 1) >= DEB) lvlNew[i] = sNow[i];
      end
      if (busIf.OUTBUS_WE && busIf.OUTBUS_ADDR == DEV + 8'd1) mRise = mRise & ~busIf.OUTBUS_DATA[PW-1:0];
      if (busIf.OUTBUS_WE && busIf.OUTBUS_ADDR == DEV + 8'd2) mFall = mFall & ~busIf.OUTBUS_DATA[PW-1:0];
      mRise  = mRise | (lvlNew & ~mLevel);
      mFall  = mFall | (mLevel & ~lvlNew);
      mEvent = |{mRise, mFall};
      mLevel = lvlNew;
      sPrev  = sNow;
      pinHist.push_back(pins);
    end
    #1;
    checkOutput("model data", busIf.INBUS_DATA, mData);
    checkOutput("model event", {7'b0, evt}, {7'b0, mEvent});
  end

  // Drive every DUT input at once (called just after a falling edge)
  task automatic applyStimulus(input logic [PW-1:0] p, input logic we, input logic [7:0] waddr,
                               input logic [7:0] wdata, input logic re, input logic [7:0] raddr);
    pins              = p;
    busIf.OUTBUS_WE   = we;
    busIf.OUTBUS_ADDR = waddr;
    busIf.OUTBUS_DATA = wdata;
    busIf.INBUS_RE    = re;
    busIf.INBUS_ADDR  = raddr;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle read strobe: data must appear on the next edge only
  task automatic readReg(input logic [7:0] addr, input logic [7:0] expected, input string name);
    @(negedge clk);
    applyStimulus(pins, 1'b0, 8'h00, 8'h00, 1'b1, addr);
    @(posedge clk);
    #2;
    checkOutput(name, busIf.INBUS_DATA, expected);
    @(negedge clk);
    applyStimulus(pins, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    checkOutput({name, " after"}, busIf.INBUS_DATA, 8'h00);
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    applyStimulus(pins, 1'b1, addr, data, 1'b0, 8'h00);
    @(negedge clk);
    applyStimulus(pins, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  // Step the pins (optionally releasing reset) from an all-zero state and
  // read LEVEL every cycle: the level changes after edge 2+DEB, so read
  // data shows it from the following edge and EVENT from that same edge
  task automatic watchStep(input logic [PW-1:0] p, input logic doRelease, input logic [7:0] expLevel);
    @(negedge clk);
    if (doRelease) reset = 1'b0;
    applyStimulus(p, 1'b0, 8'h00, 8'h00, 1'b1, DEV);
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk);
      #2;
      checkOutput($sformatf("step level e%0d", e), busIf.INBUS_DATA, (e >= DEB + 3) ? expLevel : 8'h00);
      checkOutput($sformatf("step event e%0d", e), {7'b0, evt}, (e >= DEB + 2) ? 8'h01 : 8'h00);
    end
    @(negedge clk);
    applyStimulus(pins, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus('0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    #1;
    checkOutput("reset data", busIf.INBUS_DATA, 8'h00);
    checkOutput("reset event", {7'b0, evt}, 8'h00);
    idle(3);
    reset = 1'b0;
    idle(5);

    // Clean rising step on pin0
    watchStep(5'b00001, 1'b0, 8'h01);
    readReg(DEV,        8'h01, "s1 level");
    readReg(DEV + 8'd1, 8'h01, "s1 rise");
    readReg(DEV + 8'd2, 8'h00, "s1 fall");

    // Pin2 glitch of 10 cycles is rejected
    @(negedge clk);
    applyStimulus(5'b00101, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(10);
    applyStimulus(5'b00001, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(30);
    readReg(DEV,        8'h01, "s2 level");
    readReg(DEV + 8'd1, 8'h01, "s2 rise");
    readReg(DEV + 8'd2, 8'h00, "s2 fall");

    // Pin2 held: RISE=0x05; ignored writes, then write-one-to-clear
    @(negedge clk);
    applyStimulus(5'b00101, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(25);
    readReg(DEV + 8'd1, 8'h05, "s3 rise");
    writeReg(DEV,        8'hFF);
    writeReg(DEV + 8'd3, 8'hFF);
    writeReg(8'h30,      8'hFF);
    readReg(DEV + 8'd1, 8'h05, "s3 rise after ignored");
    readReg(DEV,        8'h05, "s3 level");
    writeReg(DEV + 8'd1, 8'h01);
    readReg(DEV + 8'd1, 8'h04, "s3 rise clr0");
    checkOutput("s3 event set", {7'b0, evt}, 8'h01);
    writeReg(DEV + 8'd1, 8'h04);
    readReg(DEV + 8'd1, 8'h00, "s3 rise clr2");
    checkOutput("s3 event clear", {7'b0, evt}, 8'h00);

    // Pin0 falls, FALL cleared, then a clear coincides with the rise
    @(negedge clk);
    applyStimulus(5'b00100, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(25);
    readReg(DEV + 8'd2, 8'h01, "s4 fall");
    writeReg(DEV + 8'd2, 8'h01);
    readReg(DEV + 8'd2, 8'h00, "s4 fall clr");
    @(negedge clk);
    applyStimulus(5'b00101, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(DEB + 1);
    applyStimulus(pins, 1'b1, DEV + 8'd1, 8'h01, 1'b0, 8'h00);
    @(negedge clk);
    applyStimulus(pins, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    readReg(DEV + 8'd1, 8'h01, "s4 set wins");
    checkOutput("s4 event", {7'b0, evt}, 8'h01);

    // Unmapped reads return zero; LEVEL read only for one cycle
    readReg(DEV + 8'd3, 8'h00, "s5 read +3");
    readReg(8'h30,      8'h00, "s5 read 30");
    readReg(DEV,        8'h05, "s5 read level");

    // Reset in the middle of pin1's debounce, pins held high
    @(negedge clk);
    applyStimulus(5'b00111, 1'b0, 8'h00, 8'h00, 1'b1, DEV);
    idle(8);
    reset = 1'b1;
    #1;
    checkOutput("s6 reset data", busIf.INBUS_DATA, 8'h00);
    checkOutput("s6 reset event", {7'b0, evt}, 8'h00);
    idle(3);
    watchStep(5'b00111, 1'b1, 8'h07);
    readReg(DEV + 8'd1, 8'h07, "s6 rise");
    readReg(DEV + 8'd2, 8'h00, "s6 fall");

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
